// File: rtl/mips_io_responder.sv
// Memory-mapped I/O responder on the MIPS data bus: output port, synchronized
// input port with sticky change flag, and a compare timer.
module mips_io_responder #(
    parameter logic [31:0] IO_BASE       = 32'h1001_0040,
    parameter logic [31:0] PORTOUT_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [7:0]  PortIn,
    output logic        IoHit,
    output logic [31:0] IoReadData,
    output logic [31:0] PortOut,
    output logic        IrqPending
);

    localparam int unsigned DW = 32;
    localparam int unsigned PW = 8;

    typedef enum logic [1:0] {
        OFF_PORT_OUT = 2'd0,
        OFF_PORT_IN  = 2'd1,
        OFF_STATUS   = 2'd2,
        OFF_TIMER    = 2'd3
    } reg_off_e;

    logic [DW-1:0] port_out_q, port_out_d;
    logic [PW-1:0] s1_q, s1_d;
    logic [PW-1:0] s2_q, s2_d;
    logic [PW-1:0] in_prev_q, in_prev_d;
    logic          changed_q, changed_d;
    logic          timer_hit_q, timer_hit_d;
    logic          irq_q, irq_d;
    logic [DW-1:0] compare_q, compare_d;
    logic [DW-1:0] count_q, count_d;

    reg_off_e offset;
    logic     rd_hit;
    logic     wr_hit;
    logic     timer_match;
    logic     clr_changed;
    logic     clr_timer_hit;
    logic     unused_addr;

    assign unused_addr = ^Address[1:0];
    assign offset      = reg_off_e'(Address[3:2]);
    assign IoHit       = (Address[31:4] == IO_BASE[31:4]);
    assign rd_hit      = IoHit & MemRead;
    assign wr_hit      = IoHit & MemWrite;
    assign PortOut     = port_out_q;
    assign IrqPending  = irq_q;

    // Combinational read mux reflecting pre-edge register values
    always_comb begin
        IoReadData = '0;
        if (rd_hit) begin
            case (offset)
                OFF_PORT_OUT: IoReadData = port_out_q;
                OFF_PORT_IN:  IoReadData = DW'(s2_q);
                OFF_STATUS:   IoReadData = {30'd0, timer_hit_q, changed_q};
                OFF_TIMER:    IoReadData = count_q;
                default:      IoReadData = '0;
            endcase
        end
    end

    // Next-state logic; sticky sets always win over clears
    always_comb begin
        port_out_d    = port_out_q;
        s1_d          = PortIn;
        s2_d          = s1_q;
        in_prev_d     = s2_q;
        compare_d     = compare_q;
        count_d       = '0;
        timer_match   = 1'b0;
        clr_changed   = 1'b0;
        clr_timer_hit = 1'b0;

        if (compare_q != '0) begin
            timer_match = (count_q == compare_q);
            count_d     = timer_match ? '0 : count_q + 32'd1;
        end

        if (wr_hit) begin
            case (offset)
                OFF_PORT_OUT: port_out_d = WriteData;
                OFF_STATUS: begin
                    clr_changed   = WriteData[0];
                    clr_timer_hit = WriteData[1];
                end
                OFF_TIMER: begin
                    compare_d = WriteData;
                    count_d   = '0;
                end
                default: ;
            endcase
        end else if (rd_hit && offset == OFF_PORT_IN) begin
            clr_changed = 1'b1;
        end

        changed_d   = (s2_q != in_prev_q) | (changed_q & ~clr_changed);
        timer_hit_d = timer_match | (timer_hit_q & ~clr_timer_hit);
        irq_d       = changed_d | timer_hit_d;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            port_out_q  <= PORTOUT_RESET;
            s1_q        <= '0;
            s2_q        <= '0;
            in_prev_q   <= '0;
            changed_q   <= 1'b0;
            timer_hit_q <= 1'b0;
            irq_q       <= 1'b0;
            compare_q   <= '0;
            count_q     <= '0;
        end else begin
            port_out_q  <= port_out_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            in_prev_q   <= in_prev_d;
            changed_q   <= changed_d;
            timer_hit_q <= timer_hit_d;
            irq_q       <= irq_d;
            compare_q   <= compare_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_mips_io_responder.sv
// Scoreboard bench for mips_io_responder: directed scenarios followed by random
// bus traffic, checked against a cycle-level behavioural model.
module tb_mips_io_responder;

    localparam logic [31:0] BASE   = 32'h1001_0040;
    localparam logic [31:0] PO_RST = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [7:0]  PortIn;
    logic        IoHit;
    logic [31:0] IoReadData;
    logic [31:0] PortOut;
    logic        IrqPending;

    mips_io_responder #(.IO_BASE(BASE), .PORTOUT_RESET(PO_RST)) dut (
        .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .PortIn(PortIn),
        .IoHit(IoHit), .IoReadData(IoReadData), .PortOut(PortOut),
        .IrqPending(IrqPending)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        logic        hit;
        logic [31:0] rd;
        logic [31:0] po;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Behavioural model: pin history, register values, timer
    logic [31:0] m_po;
    logic [7:0]  pin_hist[3];   // [0]=last pin captured, [1]=in_sync, [2]=previous in_sync
    bit          m_ch, m_th;
    logic [31:0] m_cmp, m_cnt;

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic mr);
        if (a[31:4] != BASE[31:4] || !mr) return 32'd0;
        case (a[3:2])
            2'd0:    return m_po;
            2'd1:    return {24'd0, pin_hist[1]};
            2'd2:    return {30'd0, m_th, m_ch};
            default: return m_cnt;
        endcase
    endfunction

    task automatic model_step(input logic rst, input logic [31:0] a, input logic [31:0] wd,
                              input logic mw, input logic mr, input logic [7:0] pin);
        bit hit, match, chg, clr0, clr1;
        if (rst) begin
            m_po = PO_RST; m_ch = 0; m_th = 0; m_cmp = 0; m_cnt = 0;
            for (int i = 0; i < 3; i++) pin_hist[i] = 8'd0;
            return;
        end
        hit   = (a[31:4] == BASE[31:4]);
        chg   = (pin_hist[1] != pin_hist[2]);
        match = (m_cmp != 0) && (m_cnt == m_cmp);
        clr0  = (hit && mr && !mw && a[3:2] == 2'd1) || (hit && mw && a[3:2] == 2'd2 && wd[0]);
        clr1  = hit && mw && a[3:2] == 2'd2 && wd[1];
        if (m_cmp == 0 || match) m_cnt = 0;
        else                     m_cnt = m_cnt + 1;
        if (hit && mw && a[3:2] == 2'd3) begin m_cmp = wd; m_cnt = 0; end
        if (hit && mw && a[3:2] == 2'd0) m_po = wd;
        m_ch = chg   || (m_ch && !clr0);
        m_th = match || (m_th && !clr1);
        pin_hist[2] = pin_hist[1];
        pin_hist[1] = pin_hist[0];
        pin_hist[0] = pin;
    endtask

    // Drive one bus cycle (called at posedge+1), queue the expectation, advance the model
    task automatic cycle(input logic rst, input logic [31:0] a, input logic [31:0] wd,
                         input logic mw, input logic mr, input logic [7:0] pin, input bit chk);
        exp_t e;
        reset = rst; Address = a; WriteData = wd; MemWrite = mw; MemRead = mr; PortIn = pin;
        e.chk = chk;
        e.hit = (a[31:4] == BASE[31:4]);
        e.rd  = model_read(a, mr);
        e.po  = m_po;
        e.irq = m_ch | m_th;
        sb.push_back(e);
        @(posedge clk);
        model_step(rst, a, wd, mw, mr, pin);
        #1;
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [7:0] pin);
        cycle(1'b0, BASE + 32'(off), d, 1'b1, 1'b0, pin, 1'b1);
    endtask

    task automatic rd(input logic [3:0] off, input logic [7:0] pin);
        cycle(1'b0, BASE + 32'(off), 32'd0, 1'b0, 1'b1, pin, 1'b1);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop one expectation per cycle, mid-cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.chk) begin
                cmp("io_hit",      32'(IoHit),      32'(e.hit));
                cmp("io_read",     IoReadData,      e.rd);
                cmp("port_out",    PortOut,         e.po);
                cmp("irq_pending", 32'(IrqPending), 32'(e.irq));
            end
        end
    end

    initial begin
        logic [31:0] a, d;
        logic [7:0]  pin;
        logic        mw, mr;
        for (int i = 0; i < 3; i++) pin_hist[i] = 8'd0;
        m_po = PO_RST; m_ch = 0; m_th = 0; m_cmp = 0; m_cnt = 0;
        @(posedge clk); #1;

        // Reset for two cycles, then read every offset
        cycle(1'b1, BASE, 32'd0, 1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b1, BASE, 32'd0, 1'b0, 1'b1, 8'h00, 1'b1);
        for (int o = 0; o < 16; o += 4) rd(4'(o), 8'h00);

        // Output port, and a store just outside the window
        wr(4'h0, 32'hDEAD_BEEF, 8'h00);
        rd(4'h0, 8'h00);
        cycle(1'b0, BASE + 32'h10, 32'h1234_5678, 1'b1, 1'b0, 8'h00, 1'b1);
        rd(4'h0, 8'h00);

        // Input sync and change flag, then read-clear
        for (int i = 0; i < 4; i++) rd(4'h4, 8'hA5);
        rd(4'h8, 8'hA5);
        rd(4'h4, 8'hA5);
        rd(4'h8, 8'hA5);

        // Timer period and W1C, then disable
        wr(4'hC, 32'd4, 8'hA5);
        for (int i = 0; i < 7; i++) rd(4'hC, 8'hA5);
        rd(4'h8, 8'hA5);
        wr(4'h8, 32'd2, 8'hA5);
        rd(4'h8, 8'hA5);
        wr(4'hC, 32'd0, 8'hA5);
        for (int i = 0; i < 3; i++) rd(4'hC, 8'hA5);

        // Set beats clear: W1C of both bits on the cycle the timer matches
        rd(4'h0, 8'h3C);
        rd(4'h0, 8'h3C);
        wr(4'hC, 32'd4, 8'h3C);
        for (int i = 0; i < 4; i++) rd(4'h8, 8'h3C);
        wr(4'h8, 32'd3, 8'h3C);
        rd(4'h8, 8'h3C);

        // Simultaneous read+write to PORT_IN: write ignored, read-clear suppressed
        rd(4'h0, 8'h11);
        rd(4'h0, 8'h11);
        cycle(1'b0, BASE + 32'h4, 32'hFFFF_FFFF, 1'b1, 1'b1, 8'h11, 1'b1);
        rd(4'h8, 8'h11);

        // Reset mid-period with compare=10, count=7
        wr(4'h0, 32'h0BAD_F00D, 8'h11);
        wr(4'hC, 32'd10, 8'h11);
        for (int i = 0; i < 7; i++) rd(4'hC, 8'h11);
        cycle(1'b1, BASE + 32'hC, 32'd0, 1'b0, 1'b1, 8'h11, 1'b1);
        for (int i = 0; i < 12; i++) rd(4'(4 * (i % 4)), 8'h00);

        // Random traffic
        pin = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(9))
                0:       a = $urandom;
                1:       a = BASE + 32'h10 + 32'($urandom_range(15));
                default: a = BASE + 32'($urandom_range(15));
            endcase
            mw = ($urandom_range(3) == 0);
            mr = ($urandom_range(1) == 0);
            case ($urandom_range(7))
                0:       d = $urandom;
                1, 2:    d = 32'($urandom_range(3));
                default: d = 32'($urandom_range(8));
            endcase
            if ($urandom_range(15) == 0) pin = 8'($urandom);
            cycle(($urandom_range(199) == 0), a, d, mw, mr, pin, 1'b1);
        end

        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, pin, 1'b0);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_io_responder.md
# mips_io_responder

Memory-mapped I/O responder for the MIPS processor's data bus: the target side of the processor's load/store interface, sitting beside `DataMemory` and answering accesses that fall in the I/O window. It synchronizes the 8-bit `PortIn` pins, drives the 32-bit `PortOut` register, and keeps a sticky input-change flag plus a compare timer. The top level uses `IoHit` to select `IoReadData` over RAM read data on the write-back path.

## Interface

Parameters:
- `IO_BASE`, default `32'h1001_0040`. Byte address of the first register. Must be 16-byte aligned.
- `PORTOUT_RESET`, default `32'h0000_0000`. Reset value of the `PORT_OUT` register.

Ports:
- `clk`, input, 1 bit. Single clock; all state updates on its rising edge.
- `reset`, input, 1 bit. Synchronous, active-high.
- `Address`, input, 32 bits. Byte address from the ALU result or EX/MEM stage.
- `WriteData`, input, 32 bits. Store data.
- `MemWrite`, input, 1 bit. Store strobe for the current cycle.
- `MemRead`, input, 1 bit. Load strobe for the current cycle.
- `PortIn`, input, 8 bits. Asynchronous external pins.
- `IoHit`, output, 1 bit. Combinational. Asserted when `Address[31:4] == IO_BASE[31:4]`, regardless of the strobes.
- `IoReadData`, output, 32 bits. Combinational read data for the decoded register. Equals 0 when `IoHit` is 0 or `MemRead` is 0.
- `PortOut`, output, 32 bits. Registered. Equals the `PORT_OUT` register.
- `IrqPending`, output, 1 bit. Registered. Equals `STATUS[1] | STATUS[0]`.

## Operation

Register map. Offset is `Address[3:2]`; `Address[1:0]` is ignored.
- `0x0` `PORT_OUT`, read/write. A write loads `WriteData`. A read returns the register.
- `0x4` `PORT_IN`, read-only. A read returns `{24'b0, in_sync}`. A read clears `STATUS[0]`. Writes are ignored.
- `0x8` `STATUS`, read and write-1-to-clear.
  - bit0 `CHANGED`: sticky; set when `in_sync` differs from `in_prev`.
  - bit1 `TIMER_HIT`: sticky.
  - bits 31:2 always read 0.
- `0xC` `TIMER`. A write loads `compare <= WriteData` and sets `count <= 0`. A read returns `count`.

Input path:
- `PortIn` passes through a two-flop synchronizer (`s1`, `s2`), giving `in_sync = s2`.
- `in_prev <= in_sync` every cycle.
- `CHANGED` sets on any cycle where `in_sync != in_prev`.

Timer:
- `compare == 0`: timer is disabled and `count` holds 0.
- Otherwise `count` increments by 1 each cycle.
- When `count == compare`, the next state is `count <= 0` and `TIMER_HIT` sets. The period is therefore `compare + 1` cycles.
- All arithmetic is 32-bit unsigned. `compare = 32'hFFFF_FFFF` is legal; `count` wraps to 0 on the match.

Access rules:
- A side effect happens only when `IoHit` is 1 and the corresponding strobe is 1.
- If `MemRead` and `MemWrite` are both 1, the write takes effect and the read-clear is suppressed. `IoReadData` still shows the pre-edge value.
- Set beats clear in the same cycle, for a read-clear or a W1C on either STATUS bit. The bit stays 1.
- A `TIMER` write in the same cycle as a timer match loads the new compare value with `count <= 0`, and `TIMER_HIT` still sets.

## Timing

- Reads are combinational. `IoReadData` is valid in the same cycle as `Address`/`MemRead` and reflects pre-edge register values, which matches single-cycle `DataMemory` read behaviour.
- Writes and read side effects commit at the rising edge that ends the access cycle. They are visible on outputs one cycle later.
- `PortIn` to `PORT_IN`: 2 edges. A pin change before edge N appears in `in_sync` after edge N+1. `CHANGED` and `IrqPending` are 1 after edge N+2.
- Reset applies at the rising edge while `reset = 1`:
  - `PortOut = PORTOUT_RESET`
  - `s1`, `s2`, `in_prev` = 0
  - `STATUS = 0`, `IrqPending = 0`
  - `compare = 0`, `count = 0`
- Reset dominates every other event in that cycle. Asserting reset mid-period abandons the timer period, and no `TIMER_HIT` is produced.
- `IoHit` and `IoReadData` are combinational and do not depend on reset.

## Test plan

- **Reset:** Hold `reset` for 2 cycles. Expect `PortOut = 0`, `IrqPending = 0`, and `IoReadData = 0` for every offset read.
- **Port out:** Store `32'hDEAD_BEEF` to `IO_BASE+0x0`. Expect `PortOut = 32'hDEAD_BEEF` after that edge, and a read of offset 0 returning the same value. Store to `IO_BASE+0x10`. Expect `IoHit = 0` and `PortOut` unchanged.
- **Input sync and flag:**
  - Change `PortIn` from `8'h00` to `8'hA5`. Expect `PORT_IN` to read `32'h0000_00A5` after 2 edges, and `STATUS = 1` with `IrqPending = 1` after 3 edges.
  - Then read offset `0x4`. Expect `STATUS = 0` next cycle.
- **Timer:**
  - Write `TIMER = 4`. Expect `count` to read 0,1,2,3,4,0 on successive cycles and `STATUS[1]` set after the `count == 4` edge.
  - Write `STATUS = 2`. Expect the bit cleared.
  - Write `TIMER = 0`. Expect `count` to stay at 0.
- **Set versus clear:** Write `STATUS = 3` in the same cycle a timer match occurs. Expect `STATUS = 2`, meaning `TIMER_HIT` survives and `CHANGED` clears.
- **Reset mid-operation:** With `compare = 10` and `count = 7`, pulse `reset`. Expect `count = 0`, `compare = 0`, no `TIMER_HIT`, and `PortOut = PORTOUT_RESET`.
